t_ff_mod_counter: RTL and testbench

- Synchronous modulo-N up/down counter built from an array of T flip-flop cells.
- Sits directly upstream of the T flip-flop stage: it generates each cell's toggle input from the current count, direction, enable and load.
- It consumes the q outputs of those cells as its own state.
- Provides a terminal-count flag and a registered wrap pulse for cascading further counter stages.

---
 rtl/t_ff_pkg.sv | 14 +
 rtl/t_ff_cell.sv | 21 ++
 rtl/t_ff_mod_counter.sv | 62 ++++++
 tb/tb_t_ff_mod_counter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/t_ff_pkg.sv
// t_ff_pkg: shared helpers for the T flip-flop modulo counter
package t_ff_pkg;

    function automatic bit modulus_ok(int unsigned width, int unsigned modulus);
        return modulus >= 2 && modulus <= (32'd1 << width);
    endfunction

    function automatic int unsigned next_q(int unsigned q, bit up, int unsigned modulus);
        return (q >= modulus) ? 0 :
               up ? ((q == modulus - 1) ? 0 : q + 1) :
               ((q == 0) ? modulus - 1 : q - 1);
    endfunction

endpackage

// File: rtl/t_ff_cell.sv
// t_ff_cell: T flip-flop with asynchronous active-low reset
module t_ff_cell (
    input  logic t,
    input  logic clk,
    input  logic rst_n,
    output logic q,
    output logic qbar
);
    logic state_q, state_d;

    // toggle when t is high, otherwise hold
    always_comb state_d = state_q ^ t;

    // single bit of count state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= 1'b0;
        else        state_q <= state_d;

    assign q    = state_q;
    assign qbar = ~state_q;
endmodule

// File: rtl/t_ff_mod_counter.sv
// t_ff_mod_counter: modulo-N up/down counter built from T flip-flop cells
module t_ff_mod_counter
    import t_ff_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             tc,
    output logic             wrap
);
    // one extra bit so MODULUS == 2**WIDTH still fits in the compare
    localparam logic [WIDTH:0] MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] LAST = MOD - 1'b1;

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("t_ff_mod_counter: MODULUS out of range");
    end

    logic [WIDTH:0]   q_ext, din_ext;
    logic [WIDTH-1:0] nxt, t;
    logic             wrap_q, wrap_d;

    assign q_ext   = {1'b0, q};
    assign din_ext = {1'b0, din};

    // next count (load > en > hold); toggle vector is the bits that must change
    always_comb begin
        nxt = load ? ((din_ext >= MOD) ? LAST[WIDTH-1:0] : din) :
              !en ? q :
              (q_ext >= MOD) ? '0 :
              up ? ((q_ext == LAST) ? '0 : WIDTH'(q_ext + 1'b1)) :
              ((q_ext == '0) ? LAST[WIDTH-1:0] : WIDTH'(q_ext - 1'b1));
        t      = q ^ nxt;
        tc     = en & ~load & (up ? (q_ext == LAST) : (q_ext == '0));
        wrap_d = tc;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .t    (t[i]),
            .clk  (clk),
            .rst_n(rst_n),
            .q    (q[i]),
            .qbar (q_bar[i])
        );
    end

    // wrap pulse is tc delayed by one edge
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wrap_q <= 1'b0;
        else        wrap_q <= wrap_d;

    assign wrap = wrap_q;
endmodule

// File: tb/tb_t_ff_mod_counter.sv
// tb_t_ff_mod_counter: directed self-checking bench for t_ff_mod_counter
module tb_t_ff_mod_counter;
    logic       clk = 1'b0;
    logic       rst_n, en, up, load;
    logic [3:0] din, q, q_bar;
    logic       tc, wrap;
    logic       rst_c, en_c;
    logic [3:0] lo_q, lo_qb, hi_q, hi_qb;
    logic       lo_tc, lo_wrap, hi_tc, hi_wrap;
    int         n_run = 0;
    int         n_fail = 0;
    int         exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    always #5 clk = ~clk;

    t_ff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .din(din),
        .q(q), .q_bar(q_bar), .tc(tc), .wrap(wrap)
    );

    t_ff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_lo (
        .clk(clk), .rst_n(rst_c), .en(en_c), .up(1'b1), .load(1'b0), .din(4'd0),
        .q(lo_q), .q_bar(lo_qb), .tc(lo_tc), .wrap(lo_wrap)
    );

    t_ff_mod_counter #(.WIDTH(4), .MODULUS(10)) u_hi (
        .clk(clk), .rst_n(rst_c), .en(lo_tc), .up(1'b1), .load(1'b0), .din(4'd0),
        .q(hi_q), .q_bar(hi_qb), .tc(hi_tc), .wrap(hi_wrap)
    );

    task automatic check(string tag, int obs, int exp);
        n_run++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 0; en = 0; up = 1; load = 0; din = 0; rst_c = 0; en_c = 0;
        #2;
        check("rst_q", q, 0);
        check("rst_qbar", q_bar, 15);
        check("rst_wrap", wrap, 0);
        #10 rst_n = 1;
        en = 1; up = 1;
        #1 check("tc_up_q0", tc, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("up_q", q, exp_up[i]);
            check("up_qbar", q_bar, 15 - exp_up[i]);
            check("up_tc", tc, exp_up[i] == 9);
            check("up_wrap", wrap, i == 9);
        end
        load = 1; din = 0;
        tick();
        check("ld0_q", q, 0);
        check("ld0_wrap", wrap, 0);
        load = 0; up = 0;
        #1 check("dn_tc_q0", tc, 1);
        tick();
        check("dn_q9", q, 9);
        check("dn_wrap9", wrap, 1);
        check("dn_tc9", tc, 0);
        tick();
        check("dn_q8", q, 8);
        check("dn_wrap8", wrap, 0);
        tick();
        check("dn_q7", q, 7);
        load = 1; din = 4;
        #1 check("ld_tc", tc, 0);
        tick();
        check("ld4_q", q, 4);
        check("ld4_wrap", wrap, 0);
        din = 13;
        tick();
        check("ld13_clamp", q, 9);
        din = 2;
        tick();
        check("ld2_q", q, 2);
        din = 10;
        tick();
        check("ld10_clamp", q, 9);
        din = 3;
        tick();
        load = 0; up = 1;
        tick();
        tick();
        check("cnt_q5", q, 5);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_q", q, 5);
            check("hold_t", u_dut.t, 0);
            check("hold_tc", tc, 0);
        end
        en = 1; up = 0;
        tick();
        check("dirchg_q", q, 4);
        load = 1; din = 7;
        tick();
        check("pre_rst_q", q, 7);
        load = 0; en = 0;
        #3 rst_n = 0;
        #1;
        check("arst_q", q, 0);
        check("arst_qbar", q_bar, 15);
        check("arst_wrap", wrap, 0);
        #2 rst_n = 1;
        en = 1; up = 1;
        tick();
        check("rel_q", q, 1);
        #2 rst_n = 0;
        #2 rst_n = 1;
        load = 1; din = 6;
        tick();
        check("rel_load_q", q, 6);
        load = 0; en = 0;
        en_c = 1;
        #2 rst_c = 1;
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (i == 9)  begin check("cas9_lo", lo_q, 9);  check("cas9_hi", hi_q, 0); end
            if (i == 10) begin check("cas10_lo", lo_q, 0); check("cas10_hi", hi_q, 1); end
            if (i == 19) begin check("cas19_lo", lo_q, 9); check("cas19_hi", hi_q, 1); end
            if (i == 20) begin check("cas20_lo", lo_q, 0); check("cas20_hi", hi_q, 2); end
        end
        check("cas25_lo", lo_q, 5);
        check("cas25_hi", hi_q, 2);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
